uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, meaning system clock frequency used for the baud divisor table.
REQ-002 SHALL have port clk  input  1  system clock; single clock domain, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port baud_sel  input  3  rate select: 000=9600, 001=115200, 010=230400, 011=460800, 100=921600, 101-111=115200.
REQ-006 SHALL have port data  output  8  last correctly framed byte.
REQ-007 SHALL have port valid  output  1  one-cycle pulse, new byte on data.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-009 SHALL have port busy  output  1  high from the accepted start edge until return to IDLE.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer, preset to 1 on reset; all decisions SHALL use the synchronized value rx_s.
REQ-011 SHALL compute clocks-per-bit as DIV = CLK_HZ/baud, rounded to nearest; at 50 MHz: 5208, 434, 217, 109, 54.
REQ-012 SHALL latch baud_sel into DIV on start-edge detection; baud_sel changes mid-frame SHALL have no effect until the next frame.
REQ-013 SHALL implement the FSM states IDLE, START, DATA, STOP.
REQ-014 IDLE: on rx_s 1->0 transition (previous rx_s 1, current 0), go to START, clear the bit counter, set busy=1.
REQ-015 START: at count DIV/2-1 (mid start bit), if rx_s=0 go to DATA with the counter cleared; if rx_s=1 (glitch), go to IDLE with no output pulse.
REQ-016 DATA: at each count DIV-1, SHALL shift rx_s in LSB-first, clear the counter, increment the bit index 0..7; after bit 7 is sampled, go to STOP.
REQ-017 STOP: at count DIV-1, if rx_s=1, SHALL load data with the shift register and pulse valid; if rx_s=0, SHALL pulse frame_err and leave data unchanged; in both cases go to IDLE.
REQ-018 valid and frame_err SHALL each be high for exactly one clk cycle, registered, and never both high together.
REQ-019 data SHALL hold its value until the next valid pulse or reset.
REQ-020 After a frame_err, a new frame SHALL be accepted only after rx_s has been observed high (a line held low produces no further frames).
REQ-021 A start edge arriving on the cycle after the STOP exit SHALL be accepted (back-to-back frames, zero idle bits).
REQ-022 The bit counter SHALL be 13 bits wide and SHALL never wrap within a state.

Reset
REQ-023 On rst=1 at a clock edge: state=IDLE, counters=0, shift register=0, data=8'h00, valid=0, frame_err=0, busy=0, synchronizer flops=1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no valid or frame_err pulse.

Structure
REQ-025 The baud_sel encodings and the divisor table, as a function of CLK_HZ, SHALL live in the shared uart package/include, common with the transmitter.
REQ-026 The 2-flop synchronizer SHALL be a separate sub-module named sync_2ff; the rest SHALL be flat.

Verification
REQ-027 baud_sel=001, frame 0x55 from a model transmitter -> valid pulse with data=8'h55, ~9.5*434+3 cycles after the falling edge; frame_err stays 0.
REQ-028 Frames 0xAA at baud_sel=010, then 0xEF at baud_sel=011 -> data=8'hAA, then 8'hEF, one valid pulse each.
REQ-029 rx low for 100 cycles at baud_sel=001 -> no valid and no frame_err; busy returns to 0 within DIV/2+3 cycles.
REQ-030 Frame 0x3C with the stop bit driven low -> single frame_err pulse, data retains its previous value, no valid.
REQ-031 Two 0x81/0x7E frames back-to-back at 921600 -> two valid pulses, data correct each time.
REQ-032 rst pulsed during bit 4 of a frame -> all outputs at reset values, no pulses, and the next clean frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: rate-select encodings and the
// clocks-per-bit table used by both receiver and transmitter.
package uart_pkg;

  localparam int CNT_W = 13;

  localparam logic [2:0] BAUD_9600   = 3'b000;
  localparam logic [2:0] BAUD_115200 = 3'b001;
  localparam logic [2:0] BAUD_230400 = 3'b010;
  localparam logic [2:0] BAUD_460800 = 3'b011;
  localparam logic [2:0] BAUD_921600 = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_t;

  function automatic int unsigned baud_rate(
    input logic [2:0] sel
  );
    int unsigned rate;
    unique case (sel)
      BAUD_9600:   rate = 9600;
      BAUD_230400: rate = 230400;
      BAUD_460800: rate = 460800;
      BAUD_921600: rate = 921600;
      default:     rate = 115200;
    endcase
    return rate;
  endfunction

  // Clocks per bit, rounded to nearest.
  function automatic logic [CNT_W-1:0] baud_div(
    input int unsigned clk_hz,
    input logic [2:0]  sel
  );
    int unsigned rate;
    rate = baud_rate(sel);
    return CNT_W'((clk_hz + rate / 2) / rate);
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for the asynchronous rx line.
// Presets to 1 so reset looks like an idle line.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with selectable baud rate,
// mid-bit sampling and glitch/frame-error rejection.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [2:0] baud_sel,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  rx_state_t        state;
  rx_state_t        state_d;
  logic             rx_s;
  logic             rx_prev;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  logic start_edge;
  logic half_hit;
  logic full_hit;
  logic valid_d;
  logic ferr_d;
  logic sample;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // rx_prev tracks every cycle so a low line never
  // re-triggers after a frame error.
  assign start_edge = rx_prev & ~rx_s;
  assign half_hit   = cnt == ((div >> 1) - 1'b1);
  assign full_hit   = cnt == (div - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE:
        if (start_edge) state_d = ST_START;
      ST_START:
        if (half_hit)
          state_d = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:
        if (full_hit && bit_idx == 3'd7)
          state_d = ST_STOP;
      ST_STOP:
        if (full_hit) state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    sample  = 1'b0;
    unique case (1'b1)
      state == ST_STOP && full_hit: begin
        valid_d = rx_s;
        ferr_d  = ~rx_s;
      end
      state == ST_DATA && full_hit:
        sample = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_prev <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      div     <= baud_div(CLK_HZ, BAUD_115200);
    end else begin
      rx_prev <= rx_s;
      unique case (state)
        ST_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (start_edge)
            div <= baud_div(CLK_HZ, baud_sel);
        end
        ST_START:
          cnt <= half_hit ? '0 : cnt + 1'b1;
        ST_DATA:
          if (sample) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        ST_STOP:
          cnt <= full_hit ? '0 : cnt + 1'b1;
        default:
          cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= valid_d;
      frame_err <= ferr_d;
      busy      <= state_d != ST_IDLE;
      if (valid_d) data <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: model transmitter, pulse
// monitor, and one task per scenario.
module tb_uart_rx;

  localparam int D9600   = 5208;
  localparam int D115200 = 434;
  localparam int D230400 = 217;
  localparam int D460800 = 109;
  localparam int D921600 = 54;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic [2:0] baud_sel = 3'b001;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int n_both = 0;
  int v_cyc = 0;
  logic [7:0] vq[$];

  uart_rx #(.CLK_HZ(50_000_000)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .baud_sel  (baud_sel),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      vq.push_back(data);
      v_cyc = cyc;
    end
    if (frame_err) n_ferr++;
    if (valid && frame_err) n_both++;
  end

  task automatic send_frame(
    input logic [7:0] b,
    input logic [2:0] sel,
    input logic [2:0] sel_mid,
    input int         div,
    input logic       stop
  );
    baud_sel = sel;
    rx = 1'b0;
    repeat (div) @(negedge clk);
    baud_sel = sel_mid;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (div) @(negedge clk);
    end
    rx = stop;
    repeat (div) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({data, valid, frame_err, busy} !== 11'h000) begin
      errors++;
      $display("FAIL reset: data=%h v=%b fe=%b busy=%b want 00 0 0 0",
               data, valid, frame_err, busy);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single_55;
    int v0;
    int t0;
    v0 = n_valid;
    t0 = cyc;
    send_frame(8'h55, 3'b001, 3'b001, D115200, 1'b1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (n_valid - v0 !== 1 || vq[v0] !== 8'h55) begin
      errors++;
      $display("FAIL single_55: pulses=%0d data=%h want 1 55",
               n_valid - v0, data);
    end
    checks++;
    if (v_cyc - t0 !== 4126) begin
      errors++;
      $display("FAIL latency_55: got %0d cycles want 4126",
               v_cyc - t0);
    end
    checks++;
    if (n_ferr !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_55: ferr=%0d busy=%b want 0 0",
               n_ferr, busy);
    end
  endtask

  task automatic test_baud_rates;
    int v0;
    v0 = n_valid;
    // baud_sel moves mid-frame; the latched rate must hold.
    send_frame(8'hAA, 3'b010, 3'b000, D230400, 1'b1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (n_valid - v0 !== 1 || data !== 8'hAA) begin
      errors++;
      $display("FAIL rate_230400: pulses=%0d data=%h want 1 aa",
               n_valid - v0, data);
    end
    send_frame(8'hEF, 3'b011, 3'b011, D460800, 1'b1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (n_valid - v0 !== 2 || data !== 8'hEF) begin
      errors++;
      $display("FAIL rate_460800: pulses=%0d data=%h want 2 ef",
               n_valid - v0, data);
    end
    send_frame(8'h4B, 3'b111, 3'b111, D115200, 1'b1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (n_valid - v0 !== 3 || data !== 8'h4B) begin
      errors++;
      $display("FAIL rate_sel7: pulses=%0d data=%h want 3 4b",
               n_valid - v0, data);
    end
    send_frame(8'hEF, 3'b000, 3'b000, D9600, 1'b1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (n_valid - v0 !== 4 || data !== 8'hEF) begin
      errors++;
      $display("FAIL rate_9600: pulses=%0d data=%h want 4 ef",
               n_valid - v0, data);
    end
  endtask

  task automatic test_glitch;
    int v0;
    int f0;
    int t0;
    v0 = n_valid;
    f0 = n_ferr;
    baud_sel = 3'b001;
    t0 = cyc;
    rx = 1'b0;
    repeat (100) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy: busy=%b want 1", busy);
    end
    rx = 1'b1;
    while (busy === 1'b1 && cyc - t0 < 220) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_release: busy=%b after %0d cycles want 0",
               busy, cyc - t0);
    end
    repeat (D115200 * 11) @(negedge clk);
    checks++;
    if (n_valid !== v0 || n_ferr !== f0) begin
      errors++;
      $display("FAIL glitch_pulses: valid=%0d ferr=%0d want 0 0",
               n_valid - v0, n_ferr - f0);
    end
  endtask

  task automatic test_frame_err;
    int v0;
    int f0;
    v0 = n_valid;
    f0 = n_ferr;
    send_frame(8'h3C, 3'b001, 3'b001, D115200, 1'b0);
    repeat (D115200 * 12) @(negedge clk);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (n_ferr - f0 !== 1 || n_valid !== v0) begin
      errors++;
      $display("FAIL frame_err: ferr=%0d valid=%0d want 1 0",
               n_ferr - f0, n_valid - v0);
    end
    checks++;
    if (data !== 8'hEF) begin
      errors++;
      $display("FAIL frame_err_hold: data=%h want ef", data);
    end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = n_valid;
    send_frame(8'h81, 3'b100, 3'b100, D921600, 1'b1);
    send_frame(8'h7E, 3'b100, 3'b100, D921600, 1'b1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (n_valid - v0 !== 2) begin
      errors++;
      $display("FAIL b2b_count: pulses=%0d want 2", n_valid - v0);
    end else begin
      checks++;
      if (vq[v0] !== 8'h81 || vq[v0+1] !== 8'h7E) begin
        errors++;
        $display("FAIL b2b_data: got %h %h want 81 7e",
                 vq[v0], vq[v0+1]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int v0;
    int f0;
    logic [7:0] b;
    b = 8'hE5;
    v0 = n_valid;
    f0 = n_ferr;
    baud_sel = 3'b010;
    rx = 1'b0;
    repeat (D230400) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (D230400) @(negedge clk);
    end
    rx = b[4];
    repeat (D230400 / 2) @(negedge clk);
    rst = 1'b1;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({data, valid, frame_err, busy} !== 11'h000) begin
      errors++;
      $display("FAIL reset_mid: data=%h v=%b fe=%b busy=%b want 00 0 0 0",
               data, valid, frame_err, busy);
    end
    rst = 1'b0;
    repeat (D230400 * 12) @(negedge clk);
    checks++;
    if (n_valid !== v0 || n_ferr !== f0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_quiet: valid=%0d ferr=%0d busy=%b want 0 0 0",
               n_valid - v0, n_ferr - f0, busy);
    end
    send_frame(8'h96, 3'b010, 3'b010, D230400, 1'b1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (n_valid - v0 !== 1 || data !== 8'h96) begin
      errors++;
      $display("FAIL reset_recover: pulses=%0d data=%h want 1 96",
               n_valid - v0, data);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_55();
    test_baud_rates();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (n_both !== 0) begin
      errors++;
      $display("FAIL exclusive: valid and frame_err together %0d times want 0",
               n_both);
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
